// File: rtl/cache_repair_engine_if.sv
// Signal bundle for the cache repair engine: MSHR request, pipeline flush,
// memory read bus, D-cache fill port and ROB writeback. The _i/_o suffixes
// are from the engine's point of view.
interface cache_repair_engine_if #(
    parameter int LINE_WORDS = 4,
    parameter int ROB_IDX_W  = 6
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic                 flush_i;
    logic                 repair_req_i;
    logic [31:0]          repair_req_addr_i;
    logic [31:0]          repair_req_data_i;
    logic [ROB_IDX_W-1:0] repair_req_rob_idx_i;
    logic                 repair_is_store_i;
    logic                 repair_ack_o;
    logic                 repair_complete_o;
    logic                 mem_req_o;
    logic [31:0]          mem_addr_o;
    logic                 mem_gnt_i;
    logic                 mem_rvalid_i;
    logic [31:0]          mem_rdata_i;
    logic                 fill_valid_o;
    logic [31:0]          fill_line_addr_o;
    logic [IDX_W-1:0]     fill_word_idx_o;
    logic [31:0]          fill_data_o;
    logic                 fill_last_o;
    logic                 fill_dirty_o;
    logic                 wb_valid_o;
    logic [ROB_IDX_W-1:0] wb_rob_idx_o;
    logic [31:0]          wb_data_o;

    // Environment side: MSHR, pipeline, memory and cache.
    modport master (
        output flush_i, repair_req_i, repair_req_addr_i, repair_req_data_i,
               repair_req_rob_idx_i, repair_is_store_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  repair_ack_o, repair_complete_o, mem_req_o, mem_addr_o, fill_valid_o,
               fill_line_addr_o, fill_word_idx_o, fill_data_o, fill_last_o, fill_dirty_o,
               wb_valid_o, wb_rob_idx_o, wb_data_o
    );

    // Engine side.
    modport slave (
        input  flush_i, repair_req_i, repair_req_addr_i, repair_req_data_i,
               repair_req_rob_idx_i, repair_is_store_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output repair_ack_o, repair_complete_o, mem_req_o, mem_addr_o, fill_valid_o,
               fill_line_addr_o, fill_word_idx_o, fill_data_o, fill_last_o, fill_dirty_o,
               wb_valid_o, wb_rob_idx_o, wb_data_o
    );
endinterface

// File: rtl/cache_repair_engine.sv
// Cache repair engine: accepts one MSHR repair at a time, reads the missing
// line from memory critical word first (one outstanding read), streams each
// word into the D-cache fill port, merges store data into the critical word,
// then pulses completion and (unless flushed) writes back to the ROB.
module cache_repair_engine #(
    parameter int LINE_WORDS = 4,
    parameter int ROB_IDX_W  = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cache_repair_engine_if.slave bus
);
    localparam int IDX_W   = $clog2(LINE_WORDS);
    localparam int OFF_LSB = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e               state_q,  state_d;
    logic [31:OFF_LSB]    line_q,   line_d;    // line base address bits
    logic [IDX_W-1:0]     off_q,    off_d;     // critical word index
    logic [IDX_W-1:0]     beat_q,   beat_d;    // words already fetched
    logic [31:0]          sdata_q,  sdata_d;   // store data to merge
    logic [ROB_IDX_W-1:0] rob_q,    rob_d;
    logic                 store_q,  store_d;
    logic [31:0]          wbdata_q, wbdata_d;  // load result (0 for stores)
    logic                 kill_q,   kill_d;    // flush seen: suppress writeback

    // Current word index wraps naturally because LINE_WORDS is a power of two.
    logic [IDX_W-1:0] word_idx;
    assign word_idx = off_q + beat_q;

    // Next-state and output decode for the repair FSM.
    always_comb begin
        // NOTE: every next-state and output is defaulted first so no path can infer a latch.
        state_d  = state_q;
        line_d   = line_q;
        off_d    = off_q;
        beat_d   = beat_q;
        sdata_d  = sdata_q;
        rob_d    = rob_q;
        store_d  = store_q;
        wbdata_d = wbdata_q;
        kill_d   = kill_q;

        bus.repair_ack_o      = 1'b0;
        bus.repair_complete_o = 1'b0;
        bus.mem_req_o         = 1'b0;
        bus.mem_addr_o        = '0;
        bus.fill_valid_o      = 1'b0;
        bus.fill_line_addr_o  = '0;
        bus.fill_word_idx_o   = '0;
        bus.fill_data_o       = '0;
        bus.fill_last_o       = 1'b0;
        bus.fill_dirty_o      = 1'b0;
        bus.wb_valid_o        = 1'b0;
        bus.wb_rob_idx_o      = '0;
        bus.wb_data_o         = '0;

        unique case (state_q)
            S_IDLE: begin
                // Held low while in reset so every output is quiet.
                bus.repair_ack_o = bus.repair_req_i & rst_ni;
                if (bus.repair_req_i) begin
                    line_d   = bus.repair_req_addr_i[31:OFF_LSB];
                    off_d    = bus.repair_req_addr_i[OFF_LSB-1:2];
                    beat_d   = '0;
                    sdata_d  = bus.repair_req_data_i;
                    rob_d    = bus.repair_req_rob_idx_i;
                    store_d  = bus.repair_is_store_i;
                    wbdata_d = '0;
                    kill_d   = bus.flush_i;  // flush on the ack cycle kills this repair
                    state_d  = S_REQ;
                end
            end

            S_REQ: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = {line_q, word_idx, 2'b00};
                if (bus.flush_i) kill_d = 1'b1;
                if (bus.mem_gnt_i) state_d = S_WAIT;
            end

            S_WAIT: begin
                if (bus.flush_i) kill_d = 1'b1;
                if (bus.mem_rvalid_i) begin
                    bus.fill_valid_o     = 1'b1;
                    bus.fill_line_addr_o = {line_q, {OFF_LSB{1'b0}}};
                    bus.fill_word_idx_o  = word_idx;
                    bus.fill_data_o      = (store_q && beat_q == '0) ? sdata_q : bus.mem_rdata_i;
                    if (!store_q && beat_q == '0) wbdata_d = bus.mem_rdata_i;
                    if (beat_q == LAST_BEAT) begin
                        bus.fill_last_o  = 1'b1;
                        bus.fill_dirty_o = store_q;
                        state_d          = S_DONE;
                    end else begin
                        beat_d  = beat_q + IDX_W'(1);
                        state_d = S_REQ;
                    end
                end
            end

            S_DONE: begin
                bus.repair_complete_o = 1'b1;
                if (!kill_q) begin
                    bus.wb_valid_o   = 1'b1;
                    bus.wb_rob_idx_o = rob_q;
                    bus.wb_data_o    = wbdata_q;
                end
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured request fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the captured payload is reset too, so an aborted repair leaves no stale data behind.
            state_q  <= S_IDLE;
            line_q   <= '0;
            off_q    <= '0;
            beat_q   <= '0;
            sdata_q  <= '0;
            rob_q    <= '0;
            store_q  <= 1'b0;
            wbdata_q <= '0;
            kill_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            line_q   <= line_d;
            off_q    <= off_d;
            beat_q   <= beat_d;
            sdata_q  <= sdata_d;
            rob_q    <= rob_d;
            store_q  <= store_d;
            wbdata_q <= wbdata_d;
            kill_q   <= kill_d;
        end
    end
endmodule
